dec2_vector_sequencer: RTL and testbench

Sequencer that drives the shared 2-bit decrement unit (out = in − 1 mod 4) from a vector memory. For each stored vector it applies the vector to the unit, holds it for a programmable settle time, and captures the result into a result memory. It also checks each result against the expected decrement and counts mismatches. It replaces the one-shot testbench stimulus with a reusable on-chip controller, placed between the vector/result RAMs and the decrement datapath.

---
 rtl/dec2_vector_sequencer.sv | 116 +++++++++++
 tb/tb_dec2_vector_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dec2_vector_sequencer.sv
// Batch sequencer for the shared 2-bit decrement unit: fetches each stored vector,
// applies it for a programmable settle time, captures the result and counts mismatches.
module dec2_vector_sequencer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int SETTLE = 1,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   num_vec,
  output logic [ADDR_W-1:0] vec_addr,
  input  logic [1:0]        vec_data,
  output logic [1:0]        dut_in,
  input  logic [1:0]        dut_out,
  output logic              res_we,
  output logic [ADDR_W-1:0] res_addr,
  output logic [1:0]        res_data,
  output logic [ERR_W-1:0]  err_count,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_LOAD    = 3'd2;
  localparam logic [2:0] S_SETTLE  = 3'd3;
  localparam logic [2:0] S_CAPTURE = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam int CNT_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

  logic [2:0]        state;
  logic [ADDR_W:0]   n_vec;
  logic [ADDR_W:0]   num_clamped;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] res_addr_q;
  logic [1:0]        res_data_q;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        expected;
  logic              last;
  logic              mismatch;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign num_clamped = (num_vec > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : num_vec;
  assign expected    = dut_in - 2'd1;
  assign mismatch    = (dut_out != expected);
  assign last        = ({1'b0, idx} == n_vec - (ADDR_W+1)'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      n_vec      <= '0;
      idx        <= '0;
      vec_addr   <= '0;
      dut_in     <= '0;
      cnt        <= '0;
      res_addr_q <= '0;
      res_data_q <= '0;
      err_count  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            err_count <= '0;
            if (num_clamped != '0) begin
              n_vec    <= num_clamped;
              idx      <= '0;
              vec_addr <= '0;
              state    <= S_FETCH;
            end else begin
              state <= S_DONE;
            end
          end
        end
        // Memory read is in flight; data lands next cycle.
        S_FETCH: state <= S_LOAD;
        S_LOAD: begin
          dut_in <= vec_data;
          cnt    <= CNT_W'(SETTLE);
          state  <= S_SETTLE;
        end
        S_SETTLE: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= S_CAPTURE;
        end
        // Result is written through combinationally this cycle and held afterwards.
        S_CAPTURE: begin
          res_addr_q <= idx;
          res_data_q <= dut_out;
          if (mismatch) err_count <= sat_inc(err_count);
          if (last) begin
            state <= S_DONE;
          end else begin
            idx      <= idx + 1'b1;
            vec_addr <= idx + 1'b1;
            state    <= S_FETCH;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign res_we   = (state == S_CAPTURE);
  assign res_addr = res_we ? idx : res_addr_q;
  assign res_data = res_we ? dut_out : res_data_q;
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);

endmodule

// File: tb/tb_dec2_vector_sequencer.sv
// Directed bench for dec2_vector_sequencer: a SETTLE=1 instance for the vector table
// and a SETTLE=3/ERR_W=2 instance for saturation and mid-run reset.
module tb_dec2_vector_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_s   [2];
  logic       start_s [2];
  logic [4:0] num_s   [2];
  logic [3:0] va_s    [2];
  logic [1:0] vd_s    [2];
  logic [1:0] din_s   [2];
  logic [1:0] dout_s  [2];
  logic       we_s    [2];
  logic [3:0] ra_s    [2];
  logic [1:0] rd_s    [2];
  logic       busy_s  [2];
  logic       done_s  [2];
  logic [7:0] err_a;
  logic [1:0] err_b;

  logic [3:0] fmask [2];
  logic [1:0] vmem  [16];
  logic [1:0] rmem  [2][16];
  int         wr_cnt  [2];
  int         last_wa [2];

  int checks = 0;
  int errors = 0;

  dec2_vector_sequencer #(.DEPTH(16), .ADDR_W(4), .SETTLE(1), .ERR_W(8)) dut_a (
    .clk(clk), .rst(rst_s[0]), .start(start_s[0]), .num_vec(num_s[0]),
    .vec_addr(va_s[0]), .vec_data(vd_s[0]), .dut_in(din_s[0]), .dut_out(dout_s[0]),
    .res_we(we_s[0]), .res_addr(ra_s[0]), .res_data(rd_s[0]), .err_count(err_a),
    .busy(busy_s[0]), .done(done_s[0])
  );

  dec2_vector_sequencer #(.DEPTH(16), .ADDR_W(4), .SETTLE(3), .ERR_W(2)) dut_b (
    .clk(clk), .rst(rst_s[1]), .start(start_s[1]), .num_vec(num_s[1]),
    .vec_addr(va_s[1]), .vec_data(vd_s[1]), .dut_in(din_s[1]), .dut_out(dout_s[1]),
    .res_we(we_s[1]), .res_addr(ra_s[1]), .res_data(rd_s[1]), .err_count(err_b),
    .busy(busy_s[1]), .done(done_s[1])
  );

  // Decrement unit model; a faulted operand returns in+1, which never equals in-1 mod 4.
  always_comb begin
    for (int u = 0; u < 2; u++)
      dout_s[u] = fmask[u][din_s[u]] ? din_s[u] + 2'd1 : din_s[u] - 2'd1;
  end

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      vd_s[u] <= vmem[va_s[u]];
      if (we_s[u]) begin
        wr_cnt[u]            <= wr_cnt[u] + 1;
        last_wa[u]           <= int'(ra_s[u]);
        rmem[u][ra_s[u]]     <= rd_s[u];
      end
    end
  end

  function automatic int err_of(input int u);
    return (u == 0) ? int'(err_a) : int'(err_b);
  endfunction

  function automatic int all_zero(input int u);
    return (va_s[u] == 4'd0 && din_s[u] == 2'd0 && !we_s[u] && ra_s[u] == 4'd0 &&
            rd_s[u] == 2'd0 && err_of(u) == 0 && !busy_s[u] && !done_s[u]) ? 1 : 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Start a batch in the next cycle and wait (bounded) for done; reports done cycle and writes.
  task automatic run_batch(input int u, input int n, input logic [3:0] mask, input int max_cyc,
                           output int done_at, output int writes);
    int base;
    int cyc;
    fmask[u] = mask;
    @(negedge clk);
    start_s[u] = 1'b1;
    num_s[u]   = 5'(n);
    base       = wr_cnt[u];
    @(negedge clk);
    start_s[u] = 1'b0;
    cyc        = 1;
    done_at    = -1;
    chk("busy_cycle1", int'(busy_s[u]), 1);
    while (cyc <= max_cyc && done_at < 0) begin
      if (done_s[u]) done_at = cyc;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    writes = wr_cnt[u] - base;
  endtask

  typedef struct {
    int         n;
    logic [3:0] mask;
    int         exp_done;
    int         exp_err;
    int         exp_wr;
    int         exp_last;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int done_at, writes, bad, dones, first_done, base, va_before, lim;
    logic [1:0] e;

    tbl[0] = '{n: 4,  mask: 4'b0000, exp_done: 17, exp_err: 0, exp_wr: 4,  exp_last: 3};
    tbl[1] = '{n: 4,  mask: 4'b0110, exp_done: 17, exp_err: 2, exp_wr: 4,  exp_last: 3};
    tbl[2] = '{n: 0,  mask: 4'b0000, exp_done: 1,  exp_err: 0, exp_wr: 0,  exp_last: 0};
    tbl[3] = '{n: 17, mask: 4'b0000, exp_done: 65, exp_err: 0, exp_wr: 16, exp_last: 15};
    tbl[4] = '{n: 31, mask: 4'b1001, exp_done: 65, exp_err: 8, exp_wr: 16, exp_last: 15};
    tbl[5] = '{n: 1,  mask: 4'b1111, exp_done: 5,  exp_err: 1, exp_wr: 1,  exp_last: 0};

    for (int i = 0; i < 16; i++) vmem[i] = 2'(i);
    for (int u = 0; u < 2; u++) begin
      rst_s[u] = 1'b1; start_s[u] = 1'b0; num_s[u] = 5'd0; fmask[u] = 4'b0000;
    end

    // Reset then idle.
    repeat (2) @(negedge clk);
    rst_s[0] = 1'b0;
    rst_s[1] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("idle_zero_a", all_zero(0), 1);
      chk("idle_zero_b", all_zero(1), 1);
    end
    chk("idle_no_write_a", wr_cnt[0], 0);
    chk("idle_no_write_b", wr_cnt[1], 0);

    // Vector table, back-to-back batches on instance A.
    for (int r = 0; r < 6; r++) begin
      va_before = int'(va_s[0]);
      run_batch(0, tbl[r].n, tbl[r].mask, 200, done_at, writes);
      chk($sformatf("done_cycle[%0d]", r), done_at, tbl[r].exp_done);
      chk($sformatf("err_count[%0d]", r), err_of(0), tbl[r].exp_err);
      chk($sformatf("writes[%0d]", r), writes, tbl[r].exp_wr);
      if (tbl[r].exp_wr > 0) begin
        chk($sformatf("last_addr[%0d]", r), last_wa[0], tbl[r].exp_last);
        bad = 0;
        lim = (tbl[r].n > 16) ? 16 : tbl[r].n;
        for (int i = 0; i < lim; i++) begin
          e = tbl[r].mask[vmem[i]] ? vmem[i] + 2'd1 : vmem[i] - 2'd1;
          if (rmem[0][i] != e) bad++;
        end
        chk($sformatf("results[%0d]", r), bad, 0);
      end else begin
        chk($sformatf("empty_vec_addr[%0d]", r), int'(va_s[0]), va_before);
      end
    end

    // Start pulsed mid-batch is ignored.
    fmask[0] = 4'b0000;
    @(negedge clk);
    start_s[0] = 1'b1;
    num_s[0]   = 5'd4;
    base       = wr_cnt[0];
    dones      = 0;
    first_done = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start_s[0] = (c == 5) ? 1'b1 : 1'b0;
      num_s[0]   = (c == 5) ? 5'd2 : 5'd4;
      if (done_s[0]) begin
        dones++;
        if (first_done < 0) first_done = c;
      end
      if (c == 18) chk("busy_after_done", int'(busy_s[0]), 0);
    end
    chk("midstart_dones", dones, 1);
    chk("midstart_done_cycle", first_done, 17);
    chk("midstart_writes", wr_cnt[0] - base, 4);

    // Saturating error counter on instance B.
    run_batch(1, 8, 4'b1111, 100, done_at, writes);
    chk("sat_done_cycle", done_at, 49);
    chk("sat_err_count", err_of(1), 3);
    chk("sat_writes", writes, 8);
    chk("sat_last_addr", last_wa[1], 7);

    // Reset during SETTLE of vector 2 on instance B.
    fmask[1] = 4'b0000;
    @(negedge clk);
    start_s[1] = 1'b1;
    num_s[1]   = 5'd4;
    base       = wr_cnt[1];
    dones      = 0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      start_s[1] = 1'b0;
      if (done_s[1]) dones++;
      if (c == 16) begin
        chk("busy_before_rst", int'(busy_s[1]), 1);
        rst_s[1] = 1'b1;
      end
      if (c == 17) begin
        chk("rst_outputs_zero", all_zero(1), 1);
        rst_s[1] = 1'b0;
      end
    end
    chk("rst_no_done", dones, 0);
    chk("rst_writes", wr_cnt[1] - base, 2);
    chk("rst_last_addr", last_wa[1], 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
